// File: rtl/exc_pkg.sv
// Shared decode constants, cp0 cause codes and sequencer states for exc_ctrl.
package exc_pkg;
  localparam logic [5:0]  OP_SPECIAL    = 6'b000000;
  localparam logic [5:0]  FUNCT_SYSCALL = 6'b001100;
  localparam logic [5:0]  FUNCT_BREAK   = 6'b001101;
  localparam logic [5:0]  FUNCT_TEQ     = 6'b110100;
  localparam logic [31:0] ERET_WORD     = 32'h42000018;

  localparam logic [4:0] EXC_SYSCALL = 5'b01000;
  localparam logic [4:0] EXC_BREAK   = 5'b01001;
  localparam logic [4:0] EXC_TEQ     = 5'b01101;
  localparam logic [4:0] EXC_INT     = 5'b00000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    REDIRECT = 2'd2
  } state_t;
endpackage

// File: rtl/int_sync.sv
// Two-flop synchronizer for the asynchronous external interrupt level.
// Only instantiated when EXC_CTRL_EXT_INT_EN is defined; reset clears any pending request.
module int_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/exc_ctrl.sv
// Trap/eret detector and sequencer upstream of cp0: IDLE -> COMMIT (strobes) -> REDIRECT (pc_sel).
// Optional external interrupt path enabled by defining EXC_CTRL_EXT_INT_EN.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned MAX_DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] status,
  input  logic        int_req,
  output logic        exception,
  output logic        eret,
  output logic [4:0]  cause,
  output logic [31:0] exc_pc,
  output logic        stall,
  output logic        pc_sel,
  output logic [1:0]  depth,
  output logic        ovf
);
  localparam logic [1:0] MAX_D = 2'(MAX_DEPTH);

  state_t      state, state_next;
  logic        kind_eret;
  logic        load, load_eret, set_ovf;
  logic [4:0]  load_cause;
  logic        at_max;

  logic is_special, dec_sys, dec_brk, dec_teq, dec_eret, dec_trap;
  assign is_special = instr[31:26] == OP_SPECIAL;
  assign dec_sys    = is_special && instr[5:0] == FUNCT_SYSCALL;
  assign dec_brk    = is_special && instr[5:0] == FUNCT_BREAK;
  assign dec_teq    = is_special && instr[5:0] == FUNCT_TEQ && rs_data == rt_data;
  assign dec_eret   = instr == ERET_WORD;
  assign dec_trap   = dec_sys | dec_brk | dec_teq;
  assign at_max     = depth == MAX_D;

  logic int_hit;
`ifdef EXC_CTRL_EXT_INT_EN
  logic sync_int;
  logic unused_status;

  int_sync u_int_sync (
    .clk (clk),
    .rst (rst),
    .d   (int_req),
    .q   (sync_int)
  );

  // A decoded trap/eret always wins; the level interrupt simply stays pending.
  assign int_hit = sync_int & status[0] & status[10] & ~(instr_valid & (dec_trap | dec_eret));
  assign unused_status = ^{status[31:11], status[9:1]};
`else
  logic unused_int;
  assign int_hit    = 1'b0;
  assign unused_int = ^{int_req, status};
`endif

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    exception  = 1'b0;
    eret       = 1'b0;
    pc_sel     = 1'b0;
    load       = 1'b0;
    load_eret  = 1'b0;
    load_cause = cause;
    set_ovf    = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid && dec_eret) begin
          if (depth != 2'd0) begin
            load       = 1'b1;
            load_eret  = 1'b1;
            load_cause = EXC_INT;  // cp0 ignores cause on a return
          end
        end else if (instr_valid && dec_trap) begin
          if (at_max) begin
            set_ovf = 1'b1;
          end else begin
            load       = 1'b1;
            load_cause = dec_teq ? EXC_TEQ : (dec_sys ? EXC_SYSCALL : EXC_BREAK);
          end
        end else if (int_hit && !at_max) begin
          // At full depth the interrupt is left pending rather than counted as a drop.
          load       = 1'b1;
          load_cause = EXC_INT;
        end
        if (load) begin
          stall      = 1'b1;
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        exception  = 1'b1;
        eret       = kind_eret;
        stall      = 1'b1;
        state_next = REDIRECT;
      end
      REDIRECT: begin
        pc_sel     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cause     <= 5'd0;
      exc_pc    <= 32'd0;
      kind_eret <= 1'b0;
      depth     <= 2'd0;
      ovf       <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        cause     <= load_cause;
        exc_pc    <= pc;
        kind_eret <= load_eret;
      end
      if (set_ovf) ovf <= 1'b1;
      if (state == COMMIT) depth <= kind_eret ? depth - 2'd1 : depth + 2'd1;
    end
  end
endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus a randomized instruction stream vs a depth/ovf model.
module tb_exc_ctrl;
  localparam int MAXD = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'd0, pc = 32'd0, rs_data = 32'd0, rt_data = 32'd0;
  logic [31:0] status = 32'd0;
  logic        int_req = 1'b0;
  logic        exception, eret, stall, pc_sel, ovf;
  logic [4:0]  cause;
  logic [31:0] exc_pc;
  logic [1:0]  depth;

  int errors = 0;
  int checks = 0;

  logic        o_stall0, o_exc, o_eret, o_stall1, o_pcsel, o_stall2, o_ovf;
  logic [4:0]  o_cause;
  logic [31:0] o_epc;
  logic [1:0]  o_depth;

  always #5 clk = ~clk;

  exc_ctrl #(.MAX_DEPTH(MAXD)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .pc(pc),
    .rs_data(rs_data), .rt_data(rt_data), .status(status), .int_req(int_req),
    .exception(exception), .eret(eret), .cause(cause), .exc_pc(exc_pc),
    .stall(stall), .pc_sel(pc_sel), .depth(depth), .ovf(ovf)
  );

  localparam logic [31:0] W_SYSCALL = 32'h0000000C;
  localparam logic [31:0] W_BREAK   = 32'h0000000D;
  localparam logic [31:0] W_TEQ     = 32'h00220034;
  localparam logic [31:0] W_ERET    = 32'h42000018;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; instr_valid = 1'b0; int_req = 1'b0; status = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one instruction at a negedge and record what the DUT shows over the next three cycles.
  task automatic run_instr(input logic [31:0] w, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
    instr = w; pc = p; rs_data = a; rt_data = b; instr_valid = 1'b1;
    #1 o_stall0 = stall;
    @(posedge clk); @(negedge clk);
    o_exc = exception; o_eret = eret; o_cause = cause; o_epc = exc_pc; o_stall1 = stall;
    if (!o_stall1) instr_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0;
    o_pcsel = pc_sel; o_stall2 = stall;
    @(posedge clk); @(negedge clk);
    o_depth = depth; o_ovf = ovf;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({exception, eret, cause, exc_pc, stall, pc_sel, depth, ovf} !== 44'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", {exception, eret, cause, exc_pc, stall, pc_sel, depth, ovf});
    end
    rst = 1'b0;
  endtask

  task automatic test_syscall();
    do_reset();
    run_instr(W_SYSCALL, 32'h00400100, 32'd0, 32'd0);
    checks++; if (o_stall0 !== 1'b1) begin errors++; $display("FAIL sys_stall got=%b exp=1", o_stall0); end
    checks++; if (o_exc !== 1'b1) begin errors++; $display("FAIL sys_exception got=%b exp=1", o_exc); end
    checks++; if (o_eret !== 1'b0) begin errors++; $display("FAIL sys_eret got=%b exp=0", o_eret); end
    checks++; if (o_cause !== 5'b01000) begin errors++; $display("FAIL sys_cause got=%b exp=01000", o_cause); end
    checks++; if (o_epc !== 32'h00400100) begin errors++; $display("FAIL sys_exc_pc got=%h exp=00400100", o_epc); end
    checks++; if (o_pcsel !== 1'b1 || o_stall2 !== 1'b0) begin errors++; $display("FAIL sys_redirect got pc_sel=%b stall=%b exp 1/0", o_pcsel, o_stall2); end
    checks++; if (o_depth !== 2'd1) begin errors++; $display("FAIL sys_depth got=%0d exp=1", o_depth); end
  endtask

  task automatic test_teq();
    do_reset();
    run_instr(W_TEQ, 32'h00400200, 32'd5, 32'd5);
    checks++; if (o_exc !== 1'b1 || o_cause !== 5'b01101) begin errors++; $display("FAIL teq_eq got exc=%b cause=%b exp 1/01101", o_exc, o_cause); end
    run_instr(W_TEQ, 32'h00400204, 32'd5, 32'd6);
    checks++; if (o_stall0 !== 1'b0 || o_exc !== 1'b0 || o_pcsel !== 1'b0) begin errors++; $display("FAIL teq_ne got stall=%b exc=%b pc_sel=%b exp 0/0/0", o_stall0, o_exc, o_pcsel); end
    checks++; if (o_depth !== 2'd1) begin errors++; $display("FAIL teq_ne_depth got=%0d exp=1", o_depth); end
  endtask

  task automatic test_break_eret();
    do_reset();
    run_instr(W_BREAK, 32'h00400300, 32'd0, 32'd0);
    checks++; if (o_cause !== 5'b01001 || o_depth !== 2'd1) begin errors++; $display("FAIL brk got cause=%b depth=%0d exp 01001/1", o_cause, o_depth); end
    run_instr(W_ERET, 32'h80000180, 32'd0, 32'd0);
    checks++; if (o_exc !== 1'b1 || o_eret !== 1'b1) begin errors++; $display("FAIL eret_strobes got exc=%b eret=%b exp 1/1", o_exc, o_eret); end
    checks++; if (o_pcsel !== 1'b1 || o_depth !== 2'd0) begin errors++; $display("FAIL eret_tail got pc_sel=%b depth=%0d exp 1/0", o_pcsel, o_depth); end
    run_instr(W_ERET, 32'h80000184, 32'd0, 32'd0);
    checks++; if (o_stall0 !== 1'b0 || o_exc !== 1'b0 || o_eret !== 1'b0 || o_depth !== 2'd0) begin
      errors++; $display("FAIL eret_depth0 got stall=%b exc=%b eret=%b depth=%0d exp 0/0/0/0", o_stall0, o_exc, o_eret, o_depth);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 3; k++) run_instr(W_SYSCALL, 32'h00400400 + 32'(4 * k), 32'd0, 32'd0);
    checks++; if (o_depth !== 2'd3 || o_ovf !== 1'b0) begin errors++; $display("FAIL ovf_pre got depth=%0d ovf=%b exp 3/0", o_depth, o_ovf); end
    run_instr(W_SYSCALL, 32'h0040040C, 32'd0, 32'd0);
    checks++; if (o_stall0 !== 1'b0 || o_exc !== 1'b0) begin errors++; $display("FAIL ovf_drop got stall=%b exc=%b exp 0/0", o_stall0, o_exc); end
    checks++; if (o_ovf !== 1'b1 || o_depth !== 2'd3) begin errors++; $display("FAIL ovf_flag got ovf=%b depth=%0d exp 1/3", o_ovf, o_depth); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    instr = W_SYSCALL; pc = 32'h00400500; instr_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (exception !== 1'b1) begin errors++; $display("FAIL rstmid_commit got exc=%b exp=1", exception); end
    rst = 1'b1; instr_valid = 1'b0;
    #1;
    checks++;
    if ({exception, eret, stall, pc_sel, depth, cause, exc_pc} !== 43'd0) begin
      errors++; $display("FAIL rstmid_clear got=%h exp=0", {exception, eret, stall, pc_sel, depth, cause, exc_pc});
    end
    @(negedge clk); rst = 1'b0;
    run_instr(W_SYSCALL, 32'h00400504, 32'd0, 32'd0);
    checks++; if (o_exc !== 1'b1 || o_epc !== 32'h00400504 || o_depth !== 2'd1) begin
      errors++; $display("FAIL rstmid_after got exc=%b epc=%h depth=%0d exp 1/00400504/1", o_exc, o_epc, o_depth);
    end
  endtask

`ifdef EXC_CTRL_EXT_INT_EN
  task automatic test_interrupt();
    int seen;
    logic [4:0]  c;
    logic [31:0] e;
    do_reset();
    run_instr(W_SYSCALL, 32'h00400600, 32'd0, 32'd0);
    pc = 32'h00400700; status = 32'h00000701; int_req = 1'b1;
    seen = -1; c = 5'h1f; e = 32'd0;
    for (int n = 1; n <= 8 && seen < 0; n++) begin
      @(posedge clk); @(negedge clk);
      if (exception) begin seen = n; c = cause; e = exc_pc; end
    end
    int_req = 1'b0;
    checks++; if (seen < 0 || seen > 4) begin errors++; $display("FAIL int_latency got=%0d exp=1..4", seen); end
    checks++; if (c !== 5'b00000 || e !== 32'h00400700) begin errors++; $display("FAIL int_cause got cause=%b epc=%h exp 00000/00400700", c, e); end
    do_reset();
    status = 32'd0; int_req = 1'b1; seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); @(negedge clk);
      if (exception || stall) seen++;
    end
    int_req = 1'b0;
    checks++; if (seen != 0) begin errors++; $display("FAIL int_masked got=%0d responses exp=0", seen); end
  endtask
`endif

  task automatic test_random();
    int          dm;
    logic        om, take, is_eret, is_trap;
    logic [31:0] w, a, b, p;
    logic [4:0]  ec;
    do_reset();
    dm = 0; om = 1'b0;
    for (int i = 0; i < 90; i++) begin
      if (i % 30 == 29) begin do_reset(); dm = 0; om = 1'b0; end
      a = $urandom; b = a; p = {$urandom} & 32'hFFFFFFFC;
      case ($urandom_range(0, 5))
        0: w = {6'd0, 20'($urandom), 6'b001100};
        1: w = {6'd0, 20'($urandom), 6'b001101};
        2: w = {6'd0, 20'($urandom), 6'b110100};
        3: begin w = {6'd0, 20'($urandom), 6'b110100}; b = a ^ (32'd1 << $urandom_range(0, 31)); end
        4: w = W_ERET;
        default: w = {6'b001001, 26'($urandom)};
      endcase
      is_eret = (w == W_ERET);
      is_trap = (w[31:26] == 6'd0) && ((w[5:0] == 6'd12) || (w[5:0] == 6'd13) || (w[5:0] == 6'd52 && a == b));
      ec = (w[5:0] == 6'd52) ? 5'd13 : (w[5:0] == 6'd12 ? 5'd8 : 5'd9);
      take = 1'b0;
      if (is_eret) begin
        if (dm > 0) begin take = 1'b1; dm = dm - 1; end
      end else if (is_trap) begin
        if (dm < MAXD) begin take = 1'b1; dm = dm + 1; end
        else om = 1'b1;
      end
      run_instr(w, p, a, b);
      checks++; if (o_stall0 !== take || o_stall1 !== take) begin errors++; $display("FAIL rnd_stall i=%0d got=%b%b exp=%b", i, o_stall0, o_stall1, take); end
      checks++; if (o_exc !== take || o_eret !== (take & is_eret)) begin errors++; $display("FAIL rnd_strobe i=%0d got exc=%b eret=%b exp %b/%b", i, o_exc, o_eret, take, take & is_eret); end
      if (take) begin
        checks++; if (o_epc !== p) begin errors++; $display("FAIL rnd_epc i=%0d got=%h exp=%h", i, o_epc, p); end
        if (!is_eret) begin
          checks++; if (o_cause !== ec) begin errors++; $display("FAIL rnd_cause i=%0d got=%b exp=%b", i, o_cause, ec); end
        end
      end
      checks++; if (o_pcsel !== take || o_stall2 !== 1'b0) begin errors++; $display("FAIL rnd_redirect i=%0d got pc_sel=%b stall=%b exp %b/0", i, o_pcsel, o_stall2, take); end
      checks++; if (o_depth !== 2'(dm) || o_ovf !== om) begin errors++; $display("FAIL rnd_state i=%0d got depth=%0d ovf=%b exp %0d/%b", i, o_depth, o_ovf, dm, om); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_syscall();
    test_teq();
    test_break_eret();
    test_overflow();
    test_reset_mid();
`ifdef EXC_CTRL_EXT_INT_EN
    test_interrupt();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
